// File: rtl/pattern_scan_pkg.sv
// Shared types and helpers for the serial pattern-scan sequencer.
package pattern_scan_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned word_w);
    return $clog2(word_w + 1);
  endfunction

  // Zero and oversize requests both mean "scan the full word".
  function automatic int unsigned norm_len(input int unsigned len, input int unsigned word_w);
    if (len == 0 || len > word_w) return word_w;
    return len;
  endfunction

endpackage

// File: rtl/pattern_scan_controller_tracker.sv
// Accumulates match count and first match position from sampled recognizer flags.
module scan_result_tracker
  import pattern_scan_pkg::*;
#(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             smp,
  input  logic [CNT_W-1:0] pos,
  input  logic             hit,
  output logic [CNT_W-1:0] match_cnt,
  output logic             first_vld,
  output logic [CNT_W-1:0] first_pos
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_cnt <= '0;
      first_vld <= 1'b0;
      first_pos <= '0;
    end else if (clr) begin
      match_cnt <= '0;
      first_vld <= 1'b0;
      first_pos <= '0;
    end else if (smp && hit) begin
      match_cnt <= match_cnt + CNT_W'(1);
      if (!first_vld) begin
        first_vld <= 1'b1;
        first_pos <= pos;
      end
    end
  end

endmodule

// File: rtl/pattern_scan_controller.sv
// Sequencer that feeds a word MSB-first into a serial recognizer and collects its matches.
module pattern_scan_controller
  import pattern_scan_pkg::*;
#(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned CNT_W  = cnt_width(WORD_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [WORD_W-1:0] word_in,
  input  logic [CNT_W-1:0]  len_in,
  input  logic              abort,
  output logic              rec_in,
  output logic              rec_clr,
  input  logic              rec_out,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              first_vld,
  output logic [CNT_W-1:0]  first_pos
);

  state_t             state;
  logic [WORD_W-1:0]  sr;
  logic [CNT_W-1:0]   len_q;
  logic [CNT_W-1:0]   idx;
  logic               park;
  logic               accept;
  logic               abort_act;
  logic               last_bit;
  logic               smp;
  logic [CNT_W-1:0]   smp_pos;

  assign accept    = (state == IDLE) && start_valid;
  assign abort_act = abort && ((state == CLEAR) || (state == SHIFT) || (state == FLUSH));
  assign last_bit  = (idx == len_q - CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sr    <= '0;
      len_q <= '0;
      idx   <= '0;
      park  <= 1'b0;
    end else begin
      park <= 1'b0;
      case (state)
        IDLE: begin
          if (start_valid) begin
            sr    <= word_in;
            len_q <= CNT_W'(norm_len(32'(len_in), WORD_W));
            idx   <= '0;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          if (abort) begin
            park  <= 1'b1;
            state <= IDLE;
          end else begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (abort) begin
            park  <= 1'b1;
            state <= IDLE;
          end else begin
            sr  <= sr << 1;
            idx <= idx + CNT_W'(1);
            if (last_bit) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (abort) begin
            park  <= 1'b1;
            state <= IDLE;
          end else begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The recognizer output lags by one cycle: each SHIFT sample after the
  // first credits the previous bit, and FLUSH picks up the final bit.
  assign smp     = ((state == SHIFT) && (idx != '0)) || (state == FLUSH);
  assign smp_pos = (state == FLUSH) ? (len_q - CNT_W'(1)) : (idx - CNT_W'(1));

  assign rec_in      = (state == SHIFT) ? sr[WORD_W-1] : 1'b0;
  assign rec_clr     = (state == CLEAR) || park;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign start_ready = (state == IDLE) && !reset;

  scan_result_tracker #(
    .CNT_W(CNT_W)
  ) u_tracker (
    .clk       (clk),
    .reset     (reset),
    .clr       (accept || abort_act),
    .smp       (smp),
    .pos       (smp_pos),
    .hit       (rec_out),
    .match_cnt (match_cnt),
    .first_vld (first_vld),
    .first_pos (first_pos)
  );

endmodule

// File: doc/pattern_scan_controller.md
Name: pattern_scan_controller

Overview:
Sequencer for the serial bit-pattern recognizer datapath.
- Accepts a parallel word through a valid/ready handshake.
- Clears the recognizer, then drives the word into it MSB-first, one bit per clock.
- Samples the recognizer's registered match flag, compensating for its one-cycle lag.
- Reports the match count and first match position with a done pulse.
- Sits between a host/register block and one recognizer instance; it is the recognizer's only driver.

Parameters:
WORD_W, 16, width of the scanned word and the maximum scan length.
CNT_W, $clog2(WORD_W+1), width of the count and position fields.

Ports:
clk  in  1  single system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
start_valid  in  1  host requests a scan.
start_ready  out  1  controller can accept a scan; high only in IDLE.
word_in  in  WORD_W  word to scan; bit WORD_W-1 is sent first.
len_in  in  CNT_W  number of bits to scan; 0 means WORD_W; values >WORD_W clamp to WORD_W.
abort  in  1  cancels an in-flight scan.
rec_in  out  1  serial bit to the recognizer.
rec_clr  out  1  synchronous clear to the recognizer state.
rec_out  in  1  recognizer match flag, Moore/registered; reflects the bit presented the previous cycle.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse when results are valid.
match_cnt  out  CNT_W  matches found in the last completed scan.
first_vld  out  1  at least one match was found.
first_pos  out  CNT_W  bit index (0 = first bit sent) at which the first match completed.

Behaviour:
- Reset (async): state=IDLE; rec_in=0, rec_clr=0, done=0, busy=0, match_cnt=0, first_vld=0, first_pos=0. start_ready=1 once reset deasserts.
- IDLE: start_ready=1. On start_valid:
  - latch word_in into the shift register;
  - latch the effective length L (1..WORD_W);
  - clear match_cnt, first_vld, first_pos;
  - go to CLEAR.
- CLEAR (1 cycle): rec_clr=1, rec_in=0; bit index idx=0; go to SHIFT.
- SHIFT (L cycles):
  - rec_in = shift-register MSB; shift left one position per cycle; idx increments.
  - Go to FLUSH after the cycle with idx==L-1.
- FLUSH (1 cycle): rec_in=0; the final sample is taken; go to DONE.
- DONE (1 cycle): done=1, start_ready=0; go to IDLE.
- Sampling rule: rec_out is sampled in SHIFT cycles with idx>=1 (credited to position idx-1) and in FLUSH (credited to position L-1). rec_out is ignored in CLEAR and in the SHIFT cycle with idx=0.
- On a sampled match at position p: match_cnt += 1. If first_vld=0, then first_pos=p and first_vld=1.
- match_cnt cannot exceed WORD_W, so no saturation logic is needed.
- Results hold from DONE until the next accepted start.
- Latency: accept at cycle 0, done at cycle L+3. The next start can be accepted at cycle L+4.
- Abort in CLEAR, SHIFT or FLUSH:
  - next state is IDLE; no done pulse;
  - results are zeroed;
  - rec_clr=1 for the abort cycle's successor, a single cycle, to park the recognizer.
- Abort in IDLE or DONE is ignored. A DONE cycle still completes normally.
- start_valid outside IDLE is ignored; there is no queuing.
- Reset mid-scan returns everything to reset values immediately.

Decomposition:
- Package pattern_scan_pkg: state enum {IDLE, CLEAR, SHIFT, FLUSH, DONE}, CNT_W helper function, length-normalisation function (0/overflow handling).
- One natural sub-module: scan_result_tracker. It takes the sample strobe, position and rec_out, and keeps match_cnt, first_vld and first_pos, with a clear input.
- The FSM, shift register and index counter stay in the top module.

Test Plan:
(Bench uses a behavioural recognizer for overlapping pattern 1101, registered output, with WORD_W=8.)
- word=8'b1101_1010, len=8: rec_in sequence 1,1,0,1,1,0,1,0 in cycles 2..9; done at cycle 11; match_cnt=2, first_vld=1, first_pos=3.
- word=8'b1101_0000, len=0 (treated as 8): match_cnt=1, first_pos=3, done at cycle 11. Repeat with len=4: same result, done at cycle 7.
- word=8'h00, len=8: match_cnt=0, first_vld=0, first_pos=0, done at cycle 11.
- Abort asserted at cycle 5 of the scan in test 1: no done pulse; busy=0 and start_ready=1 next cycle; results=0; rec_clr pulses once.
- start_valid held high continuously: starts accepted only in IDLE; done pulses every L+4 cycles; start_ready=0 during DONE.
- reset asserted mid-SHIFT (asynchronously, between edges): all outputs zero immediately; a fresh scan of test 1 afterwards gives identical results.
